// File: rtl/uart_tx_framer_if.sv
// Host-side handshake bundle for uart_tx_framer: payload offer/accept
// plus the single-cycle acknowledge and resend requests.
interface uart_tx_framer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              ack;
  logic              resend;

  modport master (output tx_data, tx_valid, ack, resend, input tx_ready);
  modport slave  (input tx_data, tx_valid, ack, resend, output tx_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start/data/optional parity/stop sequencing at
// OVERSAMPLE clocks per bit, with RTS flow control and ack/resend frames.
module uart_tx_framer #(
  parameter int         DATA_W      = 8,
  parameter int         OVERSAMPLE  = 16,
  parameter int         STOP_BITS   = 1,
  parameter int         PARITY      = 0,
  parameter logic [7:0] ACK_CODE    = 8'hAA,
  parameter logic [7:0] RESEND_CODE = 8'hCC
) (
  input  logic             uart_sampling_clk,
  input  logic             rst_n,
  uart_tx_framer_if.slave  host,
  input  logic             USB_RTS,
  output logic             USB_TX,
  output logic             busy,
  output logic             frame_done,
  output logic             aborted
);

  localparam int BC_W = $clog2(DATA_W + 4);
  localparam int SC_W = $clog2(OVERSAMPLE);

  localparam logic [BC_W-1:0]   DATA_LAST  = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0]   STOP_LAST  = BC_W'(STOP_BITS - 1);
  localparam logic [SC_W-1:0]   SAMPLE_END = SC_W'(OVERSAMPLE - 1);
  localparam logic [DATA_W-1:0] ACK_P      = DATA_W'(ACK_CODE);
  localparam logic [DATA_W-1:0] RESEND_P   = DATA_W'(RESEND_CODE);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] HOLD  = 3'd5;

  localparam logic [1:0] SRC_DATA   = 2'd0;
  localparam logic [1:0] SRC_ACK    = 2'd1;
  localparam logic [1:0] SRC_RESEND = 2'd2;

  logic [2:0]        state, state_nx;
  logic [BC_W-1:0]   bit_cnt;
  logic [SC_W-1:0]   sample_cnt;
  logic [DATA_W-1:0] frame_reg;
  logic [DATA_W-1:0] shifted;
  logic [1:0]        src;
  logic              ack_pend, resend_pend;
  logic              ack_req, resend_req;
  logic              frame_active, bit_end, frame_last, load, par_bit;

  assign resend_req   = resend_pend | host.resend;
  assign ack_req      = ack_pend | host.ack;
  assign frame_active = (state == START) || (state == DATA) ||
                        (state == PAR) || (state == STOP);
  assign bit_end      = (sample_cnt == SAMPLE_END);
  assign frame_last   = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
  assign load         = (state == IDLE) && !USB_RTS &&
                        (resend_req || ack_req || host.tx_valid);

  // A user payload is only accepted when no control frame is waiting.
  assign host.tx_ready = rst_n && (state == IDLE) && !USB_RTS &&
                         !resend_req && !ack_req;

  assign busy       = (state != IDLE);
  assign frame_done = frame_last && !USB_RTS;
  assign shifted    = frame_reg >> bit_cnt;
  assign par_bit    = (PARITY == 1) ? ~^frame_reg : ^frame_reg;

  always_comb begin
    case (state)
      START:   USB_TX = 1'b0;
      DATA:    USB_TX = shifted[0];
      PAR:     USB_TX = par_bit;
      default: USB_TX = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (load) state_nx = START;
      START: if (USB_RTS) state_nx = HOLD;
             else if (bit_end) state_nx = DATA;
      DATA:  if (USB_RTS) state_nx = HOLD;
             else if (bit_end && bit_cnt == DATA_LAST)
               state_nx = (PARITY != 0) ? PAR : STOP;
      PAR:   if (USB_RTS) state_nx = HOLD;
             else if (bit_end) state_nx = STOP;
      STOP:  if (USB_RTS) state_nx = HOLD;
             else if (frame_last) state_nx = IDLE;
      HOLD:  if (!USB_RTS) state_nx = START;
      default: state_nx = IDLE;
    endcase
  end

  // Counters restart on every state change, so HOLD -> START replays the frame.
  always_ff @(posedge uart_sampling_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      sample_cnt  <= '0;
      frame_reg   <= '0;
      src         <= SRC_DATA;
      ack_pend    <= 1'b0;
      resend_pend <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state   <= state_nx;
      aborted <= frame_active && USB_RTS;

      if (state_nx != state) begin
        sample_cnt <= '0;
        bit_cnt    <= '0;
      end else if (frame_active) begin
        if (bit_end) begin
          sample_cnt <= '0;
          bit_cnt    <= bit_cnt + BC_W'(1);
        end else begin
          sample_cnt <= sample_cnt + SC_W'(1);
        end
      end

      if (load) begin
        if (resend_req) begin
          frame_reg <= RESEND_P;
          src       <= SRC_RESEND;
        end else if (ack_req) begin
          frame_reg <= ACK_P;
          src       <= SRC_ACK;
        end else begin
          frame_reg <= host.tx_data;
          src       <= SRC_DATA;
        end
      end

      // Clearing follows setting so a request during its own frame_done is absorbed.
      if (host.resend) resend_pend <= 1'b1;
      if (host.ack)    ack_pend    <= 1'b1;
      if (frame_done && src == SRC_RESEND) resend_pend <= 1'b0;
      if (frame_done && src == SRC_ACK)    ack_pend    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: default framing, parity/two-stop
// framing, ack/resend ordering, RTS hold/replay and mid-frame reset.
module tb_uart_tx_framer;

  logic clk;
  logic rst_n;
  logic rts_a, tx_a, busy_a, done_a, abort_a;
  logic rts_b, tx_b, busy_b, done_b, abort_b;
  int   vectors;
  int   miscompares;

  uart_tx_framer_if #(.DATA_W(8)) if_a ();
  uart_tx_framer_if #(.DATA_W(8)) if_b ();

  uart_tx_framer dut_a (
    .uart_sampling_clk (clk),
    .rst_n             (rst_n),
    .host              (if_a),
    .USB_RTS           (rts_a),
    .USB_TX            (tx_a),
    .busy              (busy_a),
    .frame_done        (done_a),
    .aborted           (abort_a)
  );

  uart_tx_framer #(.PARITY(2), .STOP_BITS(2)) dut_b (
    .uart_sampling_clk (clk),
    .rst_n             (rst_n),
    .host              (if_b),
    .USB_RTS           (rts_b),
    .USB_TX            (tx_b),
    .busy              (busy_b),
    .frame_done        (done_b),
    .aborted           (abort_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic line_of(input bit which);
    return which ? tx_b : tx_a;
  endfunction

  function automatic logic done_of(input bit which);
    return which ? done_b : done_a;
  endfunction

  function automatic logic busy_of(input bit which);
    return which ? busy_b : busy_a;
  endfunction

  function automatic logic ready_of(input bit which);
    return which ? if_b.tx_ready : if_a.tx_ready;
  endfunction

  // Call just after the load edge; slot j of 'slots' is the line level of bit j.
  task automatic run_frame(input bit which, input logic [15:0] slots,
                           input int nslots, input string tag);
    int ncyc;
    ncyc = nslots * 16;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      check_output({tag, "_tx"}, 32'(line_of(which)), 32'(slots[(c - 1) / 16]));
      check_output({tag, "_done"}, 32'(done_of(which)), 32'(c == ncyc));
      check_output({tag, "_busy"}, 32'(busy_of(which)), 32'd1);
      if (c == 1) check_output({tag, "_rdy"}, 32'(ready_of(which)), 32'd0);
    end
  endtask

  initial begin
    logic seen;
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    rts_a = 1'b0;
    rts_b = 1'b0;
    if_a.tx_data = '0; if_a.tx_valid = 1'b0; if_a.ack = 1'b0; if_a.resend = 1'b0;
    if_b.tx_data = '0; if_b.tx_valid = 1'b0; if_b.ack = 1'b0; if_b.resend = 1'b0;

    repeat (2) @(negedge clk);
    check_output("rst_tx",    32'(tx_a), 32'd1);
    check_output("rst_rdy",   32'(if_a.tx_ready), 32'd0);
    check_output("rst_busy",  32'(busy_a), 32'd0);
    check_output("rst_done",  32'(done_a), 32'd0);
    check_output("rst_abort", 32'(abort_a), 32'd0);
    check_output("rst_tx_b",  32'(tx_b), 32'd1);

    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("idle_rdy", 32'(if_a.tx_ready), 32'd1);

    // Payload offered while the host blocks: no accept until RTS drops.
    @(posedge clk); #1;
    rts_a = 1'b1; if_a.tx_valid = 1'b1; if_a.tx_data = 8'h35;
    @(negedge clk);
    check_output("rts_rdy", 32'(if_a.tx_ready), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rts_busy", 32'(busy_a), 32'd0);
    @(posedge clk); #1 rts_a = 1'b0;
    @(negedge clk);
    check_output("rts_low_rdy", 32'(if_a.tx_ready), 32'd1);
    @(posedge clk); #1 if_a.tx_valid = 1'b0;
    run_frame(1'b0, {6'b0, 1'b1, 8'h35, 1'b0}, 10, "f35");
    @(negedge clk);
    check_output("f35_idle_busy", 32'(busy_a), 32'd0);
    check_output("f35_idle_rdy",  32'(if_a.tx_ready), 32'd1);

    // Even parity, two stop bits.
    @(posedge clk); #1 if_b.tx_valid = 1'b1; if_b.tx_data = 8'h07;
    @(posedge clk); #1 if_b.tx_valid = 1'b0;
    run_frame(1'b1, {4'b0, 2'b11, 1'b1, 8'h07, 1'b0}, 12, "f07p");
    @(negedge clk);
    check_output("f07p_idle_busy", 32'(busy_b), 32'd0);

    // Simultaneous ack and resend: resend frame, one idle cycle, ack frame.
    @(posedge clk); #1 if_a.ack = 1'b1; if_a.resend = 1'b1;
    @(posedge clk); #1 if_a.ack = 1'b0; if_a.resend = 1'b0;
    run_frame(1'b0, {6'b0, 1'b1, 8'hCC, 1'b0}, 10, "fres");
    @(negedge clk);
    check_output("gap_busy", 32'(busy_a), 32'd0);
    check_output("gap_tx",   32'(tx_a), 32'd1);
    check_output("gap_rdy",  32'(if_a.tx_ready), 32'd0);
    @(posedge clk); #1;
    run_frame(1'b0, {6'b0, 1'b1, 8'hAA, 1'b0}, 10, "fack");
    @(negedge clk);
    check_output("fack_idle_rdy", 32'(if_a.tx_ready), 32'd1);

    // RTS raised during data bit 3 (cycle 70), then frame replayed whole.
    @(posedge clk); #1 if_a.tx_valid = 1'b1; if_a.tx_data = 8'hA3;
    @(posedge clk); #1 if_a.tx_valid = 1'b0;
    repeat (69) @(posedge clk);
    #1 rts_a = 1'b1;
    @(negedge clk);
    check_output("abt_bit3_tx", 32'(tx_a), 32'd0);
    check_output("abt_pre",     32'(abort_a), 32'd0);
    @(negedge clk);
    check_output("abt_pulse",   32'(abort_a), 32'd1);
    check_output("abt_hold_tx", 32'(tx_a), 32'd1);
    @(negedge clk);
    check_output("abt_once",    32'(abort_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("hold_tx",   32'(tx_a), 32'd1);
      check_output("hold_done", 32'(done_a), 32'd0);
      check_output("hold_busy", 32'(busy_a), 32'd1);
    end
    @(posedge clk); #1 rts_a = 1'b0;
    @(posedge clk); #1;
    run_frame(1'b0, {6'b0, 1'b1, 8'hA3, 1'b0}, 10, "fabt");
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = seen | done_a | busy_a;
    end
    check_output("abt_single", 32'(seen), 32'd0);

    // Reset mid-DATA with an ack pending: frame and ack both discarded.
    @(posedge clk); #1 if_a.tx_valid = 1'b1; if_a.tx_data = 8'h00;
    @(posedge clk); #1 if_a.tx_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 if_a.ack = 1'b1;
    @(posedge clk); #1 if_a.ack = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    check_output("prerst_tx",   32'(tx_a), 32'd0);
    check_output("prerst_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("midrst_tx",   32'(tx_a), 32'd1);
    check_output("midrst_busy", 32'(busy_a), 32'd0);
    check_output("midrst_rdy",  32'(if_a.tx_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | done_a | busy_a | abort_a;
    end
    check_output("postrst_quiet", 32'(seen), 32'd0);
    check_output("postrst_rdy",   32'(if_a.tx_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
